// File: rtl/pe_inst_decoder.sv
// PE-side receiver for the instruction-FIFO link: node filtering, packet decode
// into filter-row / ifmap-location commands, and ack-token credit handling.
module pe_inst_decoder #(
  parameter int         WIDTH   = 14,
  parameter logic [3:0] PE_NODE = 4'd0,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+3:0] in_data,
  output logic             ack_valid,
  input  logic             ack_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_is_filter,
  output logic [2:0]       cmd_row,
  output logic [5:0]       cmd_x,
  output logic [5:0]       cmd_y,
  output logic             cmd_ts,
  input  logic             pe_set_done,
  output logic [CNT_W-1:0] set_count,
  output logic             node_err,
  output logic             proto_err
);

  typedef enum logic [1:0] {ACK, RECV, ISSUE} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] content;
  logic [3:0]       node;
  logic             in_hs, ack_hs, cmd_hs;
  logic             node_ok, new_set;
  logic             credit, done_pend;

  assign content = in_data[WIDTH+3:4];
  assign node    = in_data[3:0];
  assign node_ok = (node == PE_NODE);
  assign new_set = (content[1:0] == 2'b00);
  assign in_hs   = in_valid & in_ready;
  assign ack_hs  = ack_valid & ack_ready;
  assign cmd_hs  = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ACK;
    else     state <= state_n;
  end

  // Return to ACK only once the PE has finished the set and its credit is spent.
  always_comb begin
    state_n = state;
    case (state)
      ACK: begin
        if (ack_hs) state_n = RECV;
      end
      RECV: begin
        if (in_hs && node_ok)                   state_n = ISSUE;
        else if (!in_hs && done_pend && !credit) state_n = ACK;
      end
      ISSUE: begin
        if (cmd_hs) state_n = (done_pend && !credit) ? ACK : RECV;
      end
      default: state_n = ACK;
    endcase
  end

  always_comb begin
    ack_valid = (state == ACK);
    in_ready  = (state == RECV);
    cmd_valid = (state == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit        <= 1'b0;
      done_pend     <= 1'b0;
      set_count     <= '0;
      node_err      <= 1'b0;
      proto_err     <= 1'b0;
      cmd_is_filter <= 1'b0;
      cmd_row       <= '0;
      cmd_x         <= '0;
      cmd_y         <= '0;
      cmd_ts        <= 1'b0;
    end else begin
      if (ack_hs) begin
        credit    <= 1'b1;
        set_count <= set_count + 1'b1;
      end
      // A completion arriving alongside the ack must not be lost.
      if (pe_set_done)  done_pend <= 1'b1;
      else if (ack_hs)  done_pend <= 1'b0;

      if (in_hs) begin
        if (!node_ok) begin
          node_err <= 1'b1;
        end else begin
          cmd_is_filter <= content[0];
          cmd_row       <= content[0] ? content[3:1] : 3'd0;
          cmd_x         <= content[0] ? 6'd0 : content[13:8];
          cmd_y         <= content[0] ? 6'd0 : content[7:2];
          cmd_ts        <= content[0] ? 1'b0 : content[1];
          if (new_set) begin
            credit <= 1'b0;
            if (!credit) proto_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_inst_decoder.sv
// Scoreboard bench for pe_inst_decoder: directed packets push expected commands
// and acks into queues; a negedge monitor pops and compares on each handshake.
module tb_pe_inst_decoder;

  typedef struct packed {
    logic       f;
    logic [2:0] row;
    logic [5:0] x;
    logic [5:0] y;
    logic       ts;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_data;
  logic        ack_valid;
  logic        ack_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_filter;
  logic [2:0]  cmd_row;
  logic [5:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic        cmd_ts;
  logic        pe_set_done;
  logic [7:0]  set_count;
  logic        node_err;
  logic        proto_err;

  int vectors = 0;
  int miscompares = 0;

  cmd_t       expQ[$];
  logic [7:0] ackQ[$];

  pe_inst_decoder #(.WIDTH(14), .PE_NODE(4'd2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ack_valid(ack_valid), .ack_ready(ack_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_filter(cmd_is_filter), .cmd_row(cmd_row),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_ts(cmd_ts),
    .pe_set_done(pe_set_done), .set_count(set_count),
    .node_err(node_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic f, input logic [2:0] row, input logic [5:0] x,
                              input logic [5:0] y, input logic ts);
    cmd_t c;
    c.f = f; c.row = row; c.x = x; c.y = y; c.ts = ts;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [17:0] pkt);
    int n = 0;
    in_data  = pkt;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL in_ready timeout: got 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every command or ack handshake must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected cmd: got %0h expected none",
                   {cmd_is_filter, cmd_row, cmd_x, cmd_y, cmd_ts});
        end else begin
          checkOutput("cmd fields", 32'({cmd_is_filter, cmd_row, cmd_x, cmd_y, cmd_ts}),
                      32'(expQ.pop_front()));
        end
      end
      if (ack_valid && ack_ready) begin
        if (ackQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected ack: got set_count %0d expected none", set_count);
        end else begin
          checkOutput("ack set_count", 32'(set_count), 32'(ackQ.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    ack_ready = 1'b1; cmd_ready = 1'b0; pe_set_done = 1'b0;
    tick(); tick();
    checkOutput("rst in_ready", 32'(in_ready), 0);
    checkOutput("rst ack_valid", 32'(ack_valid), 1);
    checkOutput("rst cmd_valid", 32'(cmd_valid), 0);
    checkOutput("rst set_count", 32'(set_count), 0);
    checkOutput("rst errs", 32'({node_err, proto_err}), 0);

    // First ack handshake right after reset release
    ackQ.push_back(8'd0);
    rst = 1'b0;
    tick();
    checkOutput("t1 set_count", 32'(set_count), 1);
    checkOutput("t1 in_ready", 32'(in_ready), 1);
    checkOutput("t1 ack_valid", 32'(ack_valid), 0);

    // Filter row 6, held under backpressure
    expQ.push_back(mk(1'b1, 3'd6, 6'd0, 6'd0, 1'b0));
    applyStimulus(18'h000D2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2 cmd_valid", 32'(cmd_valid), 1);
      checkOutput("t2 hold fields", 32'({cmd_is_filter, cmd_row}), 32'({1'b1, 3'd6}));
      checkOutput("t2 in_ready", 32'(in_ready), 0);
      tick();
    end
    cmd_ready = 1'b1;
    tick();

    // Ifmap x=5 y=3 ts=0, then a second new-set packet without credit
    expQ.push_back(mk(1'b0, 3'd0, 6'd5, 6'd3, 1'b0));
    applyStimulus(18'h050C2);
    checkOutput("t3 xy ts", 32'({cmd_x, cmd_y, cmd_ts}), 32'({6'd5, 6'd3, 1'b0}));
    tick();
    checkOutput("t3 proto_err before", 32'(proto_err), 0);
    expQ.push_back(mk(1'b0, 3'd0, 6'd7, 6'd1, 1'b0));
    applyStimulus(18'h07042);
    checkOutput("t3 proto_err", 32'(proto_err), 1);
    tick();
    ack_ready = 1'b0;
    pe_set_done = 1'b1;
    tick();
    pe_set_done = 1'b0;
    checkOutput("t3 ack not yet", 32'(ack_valid), 0);
    tick();
    checkOutput("t3 ack_valid", 32'(ack_valid), 1);
    checkOutput("t3 in_ready", 32'(in_ready), 0);
    ackQ.push_back(8'd1);
    ack_ready = 1'b1;
    tick();
    checkOutput("t3 set_count", 32'(set_count), 2);

    // Wrong node is dropped
    applyStimulus(18'h000D5);
    checkOutput("t4 node_err", 32'(node_err), 1);
    checkOutput("t4 cmd_valid", 32'(cmd_valid), 0);
    checkOutput("t4 in_ready", 32'(in_ready), 1);

    // Set-done coincident with the ack handshake keeps done_pend
    ack_ready = 1'b0;
    expQ.push_back(mk(1'b0, 3'd0, 6'd2, 6'd4, 1'b0));
    applyStimulus(18'h02102);
    tick();
    pe_set_done = 1'b1;
    tick();
    pe_set_done = 1'b0;
    tick();
    checkOutput("t5 ack_valid", 32'(ack_valid), 1);
    ackQ.push_back(8'd2);
    ack_ready = 1'b1;
    pe_set_done = 1'b1;
    tick();
    pe_set_done = 1'b0;
    repeat (3) tick();
    checkOutput("t5 no second ack", 32'({ack_valid, in_ready}), 32'({1'b0, 1'b1}));
    checkOutput("t5 set_count", 32'(set_count), 3);
    expQ.push_back(mk(1'b0, 3'd0, 6'd1, 6'd1, 1'b0));
    ackQ.push_back(8'd3);
    applyStimulus(18'h01042);
    tick();
    checkOutput("t5 second ack", 32'(ack_valid), 1);
    tick();
    checkOutput("t5 set_count after", 32'(set_count), 4);

    // Reset while a command is pending
    cmd_ready = 1'b0;
    expQ.push_back(mk(1'b1, 3'd3, 6'd0, 6'd0, 1'b0));
    applyStimulus(18'h00072);
    checkOutput("t6 cmd_valid before", 32'(cmd_valid), 1);
    rst = 1'b1;
    expQ.delete();
    tick();
    checkOutput("t6 cmd_valid", 32'(cmd_valid), 0);
    checkOutput("t6 set_count", 32'(set_count), 0);
    checkOutput("t6 ack_valid", 32'(ack_valid), 1);
    checkOutput("t6 errs cleared", 32'({node_err, proto_err}), 0);
    checkOutput("t6 cmd_row cleared", 32'(cmd_row), 0);
    ackQ.push_back(8'd0);
    rst = 1'b0;
    cmd_ready = 1'b1;
    tick();

    // set_count wraps 255 -> 0
    pe_set_done = 1'b1;
    for (int k = 1; k < 256; k++) begin
      expQ.push_back(mk(1'b0, 3'd0, 6'd0, 6'd1, 1'b0));
      ackQ.push_back(8'(k));
      applyStimulus(18'h00042);
    end
    tick(); tick();
    pe_set_done = 1'b0;
    checkOutput("wrap set_count", 32'(set_count), 0);

    repeat (3) tick();
    checkOutput("cmd queue drained", 32'(expQ.size()), 0);
    checkOutput("ack queue drained", 32'(ackQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
